// File: rtl/lector_destinos_pkg.sv
// Shared definitions for the destination reader: FSM encoding and word layout.
package lector_destinos_pkg;

    localparam int WORD_W_DEF = 6;

    // Word layout: VC flag, destination index, payload nibble.
    localparam int VC_BIT   = 5;
    localparam int DEST_BIT = 4;
    localparam int DATA_HI  = 3;
    localparam int DATA_LO  = 0;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_READ = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic word_vc(input logic [WORD_W_DEF-1:0] w);
        return w[VC_BIT];
    endfunction

    function automatic logic word_dest(input logic [WORD_W_DEF-1:0] w);
        return w[DEST_BIT];
    endfunction

    function automatic logic [DATA_HI-DATA_LO:0] word_data(input logic [WORD_W_DEF-1:0] w);
        return w[DATA_HI:DATA_LO];
    endfunction

endpackage

// File: rtl/lector_destinos_arbitro.sv
// Two-way round-robin arbiter. The priority pointer only moves when both
// requesters competed, so a lone requester never steals the other's turn.
module arbitro_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic ptr;

    // Grant the pointer's favourite when both request, otherwise the only requester.
    always_comb begin
        grant = ptr;
        if (req == 2'b01) begin
            grant = 1'b0;
        end else if (req == 2'b10) begin
            grant = 1'b1;
        end
    end

    // Hand priority to the other side after a contested pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            ptr <= ~grant;
        end
    end

endmodule

// File: rtl/lector_destinos.sv
// Reads words from two destination FIFOs with round-robin arbitration,
// tracks one in-flight pop, and reports the received word plus statistics.
module lector_destinos
    import lector_destinos_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic              idle_in,
    input  logic              error_in,
    input  logic              enable,
    input  logic              empty_D0,
    input  logic              empty_D1,
    input  logic [WORD_W-1:0] data_D0,
    input  logic [WORD_W-1:0] data_D1,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              dest_out,
    output logic              mismatch_err,
    output logic [CNT_W-1:0]  count_D0,
    output logic [CNT_W-1:0]  count_D1,
    output logic              drained,
    output logic [1:0]        state_out
);

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              can_pop;
    logic              pop_any;
    logic              tag_valid;
    logic              tag_idx;
    logic [WORD_W-1:0] cap_word;

    arbitro_rr u_arbitro (
        .clk     (clk),
        .reset   (reset),
        .req     ({~empty_D1, ~empty_D0}),
        .advance (pop_any),
        .grant   (grant)
    );

    // Pop strobes follow the grant; only one FIFO can be granted per cycle.
    always_comb begin
        can_pop = (state == ST_READ) && enable;
        pop_D0  = can_pop && !empty_D0 && (grant == 1'b0);
        pop_D1  = can_pop && !empty_D1 && (grant == 1'b1);
        pop_any = pop_D0 || pop_D1;
    end

    // Next-state logic; an error overrides everything and HALT is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: if (active_in)  state_next = ST_READ;
            ST_READ: if (!active_in) state_next = ST_WAIT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_WAIT;
        endcase
        if (error_in) begin
            state_next = ST_HALT;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // In-flight tag remembers which FIFO was popped so its data can be captured next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= 1'b0;
            tag_idx   <= 1'b0;
        end else begin
            tag_valid <= pop_any;
            if (pop_any) begin
                tag_idx <= pop_D1;
            end
        end
    end

    assign cap_word = tag_idx ? data_D1 : data_D0;

    // Capture the popped word, flag destination mismatches and count per destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            dest_out     <= 1'b0;
            mismatch_err <= 1'b0;
            count_D0     <= '0;
            count_D1     <= '0;
        end else begin
            valid_out <= tag_valid;
            if (tag_valid) begin
                data_out <= cap_word;
                dest_out <= tag_idx;
                if (cap_word[DEST_BIT] != tag_idx) begin
                    mismatch_err <= 1'b1;
                end
                if (!tag_idx && (count_D0 != {CNT_W{1'b1}})) begin
                    count_D0 <= count_D0 + 1'b1;
                end
                if (tag_idx && (count_D1 != {CNT_W{1'b1}})) begin
                    count_D1 <= count_D1 + 1'b1;
                end
            end
        end
    end

    assign drained   = (state == ST_READ) && empty_D0 && empty_D1 && !tag_valid && idle_in;
    assign state_out = state;

endmodule

// File: tb/tb_lector_destinos.sv
// Scoreboard bench for lector_destinos: FIFO model, expected-word queue and monitor.
module tb_lector_destinos;

    typedef struct {
        logic [5:0] data;
        logic       dest;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       active_in;
    logic       idle_in;
    logic       error_in;
    logic       enable;
    logic       empty_D0;
    logic       empty_D1;
    logic [5:0] data_D0;
    logic [5:0] data_D1;
    logic       pop_D0;
    logic       pop_D1;
    logic [5:0] data_out;
    logic       valid_out;
    logic       dest_out;
    logic       mismatch_err;
    logic [7:0] count_D0;
    logic [7:0] count_D1;
    logic       drained;
    logic [1:0] state_out;

    logic [5:0] fifo0[$];
    logic [5:0] fifo1[$];
    exp_t       exp_q[$];
    int         pop_cyc[$];
    int         cyc;
    int         pop_total;
    int         checks;
    int         fails;

    lector_destinos #(.CNT_W(8), .WORD_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .active_in    (active_in),
        .idle_in      (idle_in),
        .error_in     (error_in),
        .enable       (enable),
        .empty_D0     (empty_D0),
        .empty_D1     (empty_D1),
        .data_D0      (data_D0),
        .data_D1      (data_D1),
        .pop_D0       (pop_D0),
        .pop_D1       (pop_D1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .dest_out     (dest_out),
        .mismatch_err (mismatch_err),
        .count_D0     (count_D0),
        .count_D1     (count_D1),
        .drained      (drained),
        .state_out    (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // FIFO model: read data appears the cycle after the pop; empties refresh after each edge.
    initial begin
        data_D0   = '0;
        data_D1   = '0;
        empty_D0  = 1'b1;
        empty_D1  = 1'b1;
        cyc       = 0;
        pop_total = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pop_cyc.delete();
            end else begin
                if (pop_D0 && pop_D1) begin
                    checkOutput("single_pop", {30'd0, pop_D1, pop_D0}, 32'h1);
                end
                if (pop_D0 && fifo0.size() > 0) begin
                    data_D0 <= fifo0.pop_front();
                    pop_cyc.push_back(cyc);
                    pop_total++;
                end else if (pop_D1 && fifo1.size() > 0) begin
                    data_D1 <= fifo1.pop_front();
                    pop_cyc.push_back(cyc);
                    pop_total++;
                end
            end
            #1;
            empty_D0 = (fifo0.size() == 0);
            empty_D1 = (fifo1.size() == 0);
            @(negedge clk);
            #1;
            empty_D0 = (fifo0.size() == 0);
            empty_D1 = (fifo1.size() == 0);
        end
    end

    // Monitor: every valid_out must match the oldest expected word and arrive one edge after the tag edge.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_valid: got data %0h dest %0b, expected no word", data_out, dest_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("data_out", {26'd0, data_out}, {26'd0, e.data});
                    checkOutput("dest_out", {31'd0, dest_out}, {31'd0, e.dest});
                    if (pop_cyc.size() > 0) begin
                        checkOutput("latency_edges", cyc - pop_cyc.pop_front(), 1);
                    end else begin
                        checkOutput("latency_pop_seen", 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic act, input logic en, input logic idle, input logic err);
        @(negedge clk);
        active_in = act;
        enable    = en;
        idle_in   = idle;
        error_in  = err;
    endtask

    task automatic expectWord(input logic [5:0] d, input logic dst);
        exp_t e;
        e.data = d;
        e.dest = dst;
        exp_q.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        active_in = 1'b0;
        enable    = 1'b0;
        idle_in   = 1'b0;
        error_in  = 1'b0;
        fifo0.delete();
        fifo1.delete();
        exp_q.delete();
        #1;
        checkOutput("rst_valid", {31'd0, valid_out}, 0);
        checkOutput("rst_data", {26'd0, data_out}, 0);
        checkOutput("rst_counts", {16'd0, count_D1, count_D0}, 0);
        checkOutput("rst_mismatch", {31'd0, mismatch_err}, 0);
        checkOutput("rst_state", {30'd0, state_out}, 0);
        checkOutput("rst_pops", {30'd0, pop_D1, pop_D0}, 0);
        checkOutput("rst_drained", {31'd0, drained}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int pre;
        logic [8:0] iv;
        checks    = 0;
        fails     = 0;
        reset     = 1'b1;
        active_in = 1'b0;
        idle_in   = 1'b0;
        error_in  = 1'b0;
        enable    = 1'b0;

        // Single word from D1 with D0 empty.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        fifo1.push_back(6'h1B);
        expectWord(6'h1B, 1'b1);
        waitDrain(20);
        checkOutput("t1_count_D1", {24'd0, count_D1}, 1);
        checkOutput("t1_count_D0", {24'd0, count_D0}, 0);
        checkOutput("t1_mismatch", {31'd0, mismatch_err}, 0);
        checkOutput("t1_state", {30'd0, state_out}, 1);

        // Round-robin between two loaded FIFOs, one pop per cycle.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        fifo0.push_back(6'h2D);
        fifo0.push_back(6'h0A);
        fifo1.push_back(6'h1B);
        fifo1.push_back(6'h1A);
        expectWord(6'h2D, 1'b0);
        expectWord(6'h1B, 1'b1);
        expectWord(6'h0A, 1'b0);
        expectWord(6'h1A, 1'b1);
        pre = pop_total;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t2_back_to_back_pops", pop_total - pre, 4);
        waitDrain(20);
        checkOutput("t2_counts", {16'd0, count_D1, count_D0}, 32'h0202);
        checkOutput("t2_mismatch", {31'd0, mismatch_err}, 0);

        // Destination mismatch is sticky across later correct traffic.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        fifo0.push_back(6'h1B);
        expectWord(6'h1B, 1'b0);
        waitDrain(20);
        checkOutput("t3_mismatch_set", {31'd0, mismatch_err}, 1);
        @(negedge clk);
        fifo0.push_back(6'h05);
        fifo1.push_back(6'h13);
        expectWord(6'h05, 1'b0);
        expectWord(6'h13, 1'b1);
        waitDrain(20);
        checkOutput("t3_mismatch_held", {31'd0, mismatch_err}, 1);
        checkOutput("t3_counts", {16'd0, count_D1, count_D0}, 32'h0102);

        // Error the cycle after a pop: word still delivered, then HALT with no pops.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        fifo0.push_back(6'h2D);
        fifo1.push_back(6'h1B);
        fifo1.push_back(6'h1A);
        expectWord(6'h2D, 1'b0);
        pre = pop_total;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        waitDrain(10);
        checkOutput("t4_pops_after_halt", pop_total - pre, 1);
        checkOutput("t4_state_halt", {30'd0, state_out}, 2);
        checkOutput("t4_count_D0", {24'd0, count_D0}, 1);

        // Reset the cycle after a pop discards the in-flight word.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        fifo0.push_back(6'h0A);
        pre = pop_total;
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        active_in = 1'b0;
        #1;
        checkOutput("t5_pop_happened", pop_total - pre, 1);
        checkOutput("t5_valid_in_reset", {31'd0, valid_out}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t5_state_wait", {30'd0, state_out}, 0);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t5_valid_after", {31'd0, valid_out}, 0);
        checkOutput("t5_counts", {16'd0, count_D1, count_D0}, 0);

        // 300 words to D0: counter saturates, then drained once idle.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            iv = i[8:0];
            fifo0.push_back({iv[0], 1'b0, iv[3:0]});
            expectWord({iv[0], 1'b0, iv[3:0]}, 1'b0);
        end
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t6_drained_busy", {31'd0, drained}, 0);
        waitDrain(400);
        checkOutput("t6_count_D0_sat", {24'd0, count_D0}, 255);
        checkOutput("t6_count_D1", {24'd0, count_D1}, 0);
        checkOutput("t6_drained", {31'd0, drained}, 1);
        checkOutput("t6_mismatch", {31'd0, mismatch_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lector_destinos.md
LECTOR_DESTINOS -- requirements
Module: lector_destinos

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the per-destination word counters.
REQ-002 SHALL have parameter WORD_W, default 6, width of a transaction word: bit5 VC, bit4 destination, bits3:0 data.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port active_in, input, 1: transaction layer active flag.
REQ-006 SHALL have port idle_in, input, 1: transaction layer idle flag.
REQ-007 SHALL have port error_in, input, 1: transaction layer error flag.
REQ-008 SHALL have port enable, input, 1: consumer permits reads.
REQ-009 SHALL have ports empty_D0 and empty_D1, inputs, 1 each: destination FIFO empty flags.
REQ-010 SHALL have ports data_D0 and data_D1, inputs, WORD_W each: destination FIFO read data, valid the cycle after the pop.
REQ-011 SHALL have ports pop_D0 and pop_D1, outputs, 1 each: destination FIFO pop strobes.
REQ-012 SHALL have ports data_out (output, WORD_W), valid_out (output, 1) and dest_out (output, 1): received word, its qualifier, and its source FIFO index.
REQ-013 SHALL have port mismatch_err, output, 1: sticky destination-mismatch flag.
REQ-014 SHALL have ports count_D0 and count_D1, outputs, CNT_W each: words received per destination.
REQ-015 SHALL have port drained, output, 1: all traffic consumed.
REQ-016 SHALL have port state_out, output, 2: current FSM state.

Function
REQ-017 SHALL implement FSM states WAIT, READ and HALT.
- WAIT to READ when active_in=1.
- READ to WAIT when active_in=0.
- Any state to HALT when error_in=1.
- HALT is left only by reset.
REQ-018 SHALL drive pop_Dx combinationally: state==READ, enable=1, empty_Dx=0 and grant==x; at most one pop per cycle.
REQ-019 SHALL arbitrate round-robin when both FIFOs are non-empty.
- Grant pointer toggles after each pop.
- When only one FIFO is non-empty, that FIFO is granted without changing pointer priority.
REQ-020 SHALL register a one-entry in-flight tag (valid plus index) on each pop.
REQ-021 SHALL capture data_Dx of the tagged FIFO on the following edge.
REQ-022 SHALL assert valid_out for exactly one cycle per popped word, with data_out and dest_out valid in the same cycle.
REQ-023 SHALL have latency as follows: pop in cycle N gives valid_out in cycle N+2.
REQ-024 SHALL sustain back-to-back pops, giving throughput of one word per cycle.
REQ-025 SHALL set mismatch_err when captured bit4 differs from dest_out; the word is still delivered and mismatch_err holds until reset.
REQ-026 SHALL increment count_Dx on each valid_out for destination x, saturating at all-ones with no wrap.
REQ-027 SHALL still deliver an in-flight word when enable falls, active_in falls or HALT is entered; no new pops are issued in those cases.
REQ-028 SHALL assert drained when state==READ, empty_D0=1, empty_D1=1, no word is in flight and idle_in=1.

Reset
REQ-029 SHALL, while reset=1, asynchronously force:
- state to WAIT and the grant pointer to D0;
- the in-flight tag clear, valid_out 0, data_out 0 and dest_out 0;
- mismatch_err 0, count_D0 0, count_D1 0 and drained 0.
REQ-030 SHALL hold pop_D0 and pop_D1 at 0 during reset, since state is WAIT.
REQ-031 SHALL discard any in-flight word on reset mid-operation; no valid_out follows reset release.

Structure
REQ-032 SHALL take the following from a shared package:
- FSM state encoding (WAIT=0, READ=1, HALT=2);
- word field positions (VC bit 5, destination bit 4, data bits 3:0);
- WORD_W default.
REQ-033 SHALL place round-robin grant logic in sub-module arbitro_rr (inputs req[1:0] and advance; output grant).

Verification
REQ-034 SHALL cover: reset, active_in=1, D1 holds 6'h1B, D0 empty -> pop_D1 in one cycle, valid_out two cycles later, data_out=6'h1B, dest_out=1, count_D1=1, mismatch_err=0.
REQ-035 SHALL cover: D0 holds 6'h2D and 6'h0A, D1 holds 6'h1B and 6'h1A, enable=1 -> pops alternate D0, D1, D0, D1 on consecutive cycles, with outputs 2D, 1B, 0A, 1A.
REQ-036 SHALL cover: D0 delivers 6'h1B (bit4=1) -> word output with dest_out=0 and mismatch_err=1, held after further correct traffic.
REQ-037 SHALL cover: error_in pulsed the cycle after a pop -> that word is delivered, state_out=HALT, no further pops while FIFOs are non-empty.
REQ-038 SHALL cover: reset asserted the cycle after a pop -> valid_out stays 0, counts are 0, state_out=WAIT after release.
REQ-039 SHALL cover: 300 words to D0 with CNT_W=8 -> count_D0 saturates at 255; drained=1 once both FIFOs are empty and idle_in=1.
